stack_cpu_core: RTL and testbench

Parametrised successor of the 16-bit stack CPU. It generalises data width, program and data address widths, and operand-stack depth. It adds branches, subroutine call/return on a dedicated return stack, stack overflow/underflow detection, and a halt state. Program and data memories are external; the core drives synchronous-read memory ports and is the top-level execution engine between the program ROM and the data RAM.

---
 rtl/stack_cpu_core_pkg.sv | 39 +++
 rtl/stack_cpu_core_lifo_file.sv | 57 +++++
 rtl/stack_cpu_core.sv | 183 ++++++++++++++++++
 tb/tb_stack_cpu_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_cpu_core_pkg.sv
// Shared definitions for the stack CPU: opcode encodings, FSM states and fault codes.
package stack_cpu_core_pkg;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_PUSHI = 5'h01;
  localparam logic [4:0] OP_LOAD  = 5'h02;
  localparam logic [4:0] OP_STORE = 5'h03;
  localparam logic [4:0] OP_DUP   = 5'h04;
  localparam logic [4:0] OP_DROP  = 5'h05;
  localparam logic [4:0] OP_JMP   = 5'h06;
  localparam logic [4:0] OP_JZ    = 5'h07;
  localparam logic [4:0] OP_CALL  = 5'h08;
  localparam logic [4:0] OP_RET   = 5'h09;
  localparam logic [4:0] OP_HALT  = 5'h0F;
  localparam logic [4:0] OP_ADD   = 5'h10;
  localparam logic [4:0] OP_SUB   = 5'h11;
  localparam logic [4:0] OP_AND   = 5'h12;
  localparam logic [4:0] OP_OR    = 5'h13;
  localparam logic [4:0] OP_XOR   = 5'h14;
  localparam logic [4:0] OP_SHL   = 5'h15;
  localparam logic [4:0] OP_SHR   = 5'h16;
  localparam logic [4:0] OP_NOT   = 5'h17;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    F_NONE      = 2'd0,
    F_OVERFLOW  = 2'd1,
    F_UNDERFLOW = 2'd2,
    F_ILLEGAL   = 2'd3
  } fault_e;

endpackage

// File: rtl/stack_cpu_core_lifo_file.sv
// Register-array LIFO with combinational TOS/NOS reads and push/pop/replace controls.
module lifo_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         tos,
  output logic [WIDTH-1:0]         nos,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    top_c;
  logic [CW-1:0]    nos_c;
  logic [CW-1:0]    wr_c;

  // pop+replace writes the NOS slot, giving a two-in/one-out update in one edge
  always_comb begin
    top_c = cnt_q - CW'(1);
    nos_c = cnt_q - CW'(2);
    wr_c  = push ? cnt_q : (pop ? nos_c : top_c);
  end

  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign tos   = empty ? '0 : mem[top_c[AW-1:0]];
  assign nos   = (cnt_q < CW'(2)) ? '0 : mem[nos_c[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push || replace) begin
      mem[wr_c[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push && !pop) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/stack_cpu_core.sv
// Multi-cycle stack CPU: FETCH/DECODE/EXEC(/MEM) sequencer with operand and return stacks.
module stack_cpu_core
  import stack_cpu_core_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned PC_WIDTH = 6,
  parameter int unsigned DA_WIDTH = 7,
  parameter int unsigned SDEPTH   = 32,
  parameter int unsigned RDEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [PC_WIDTH-1:0]       imem_addr,
  output logic                      imem_re,
  input  logic [15:0]               imem_rdata,
  output logic [DA_WIDTH-1:0]       dmem_addr,
  output logic                      dmem_re,
  output logic                      dmem_we,
  output logic [DWIDTH-1:0]         dmem_wdata,
  input  logic [DWIDTH-1:0]         dmem_rdata,
  output logic                      halted,
  output logic [1:0]                fault,
  output logic [$clog2(SDEPTH):0]   sp,
  output logic [DWIDTH-1:0]         tos
);

  localparam int unsigned SPW = $clog2(SDEPTH) + 1;

  state_e              state_q, state_d;
  fault_e              fault_q, fault_d, err;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;

  logic [4:0]          opcode;
  logic [10:0]         operand;
  logic [PC_WIDTH-1:0] target;
  logic [DWIDTH-1:0]   imm;
  logic [DWIDTH-1:0]   alu_res;

  logic                s_push, s_pop, s_rep;
  logic [DWIDTH-1:0]   s_din, s_tos, s_nos;
  logic [SPW-1:0]      s_count;
  logic                s_full, s_empty;

  logic                r_push, r_pop;
  logic [PC_WIDTH-1:0] r_tos, r_nos;
  logic [$clog2(RDEPTH):0] r_count;
  logic                r_full, r_empty;
  logic                rs_unused;

  assign opcode  = ir_q[15:11];
  assign operand = ir_q[10:0];
  assign target  = operand[PC_WIDTH-1:0];

  always_comb begin
    imm        = '0;
    imm[10:0]  = operand;
  end

  always_comb begin
    alu_res = '0;
    case (opcode[2:0])
      3'd0: alu_res = s_nos + s_tos;
      3'd1: alu_res = s_nos - s_tos;
      3'd2: alu_res = s_nos & s_tos;
      3'd3: alu_res = s_nos | s_tos;
      3'd4: alu_res = s_nos ^ s_tos;
      3'd5: alu_res = s_nos << s_tos[3:0];
      3'd6: alu_res = s_nos >> s_tos[3:0];
      3'd7: alu_res = ~s_tos;
      default: alu_res = '0;
    endcase
  end

  lifo_file #(.WIDTH(DWIDTH), .DEPTH(SDEPTH)) u_opstack (
    .clk(clk), .rst_n(rst), .push(s_push), .pop(s_pop), .replace(s_rep), .din(s_din),
    .tos(s_tos), .nos(s_nos), .count(s_count), .full(s_full), .empty(s_empty)
  );

  lifo_file #(.WIDTH(PC_WIDTH), .DEPTH(RDEPTH)) u_retstack (
    .clk(clk), .rst_n(rst), .push(r_push), .pop(r_pop), .replace(1'b0), .din(pc_q),
    .tos(r_tos), .nos(r_nos), .count(r_count), .full(r_full), .empty(r_empty)
  );

  assign rs_unused = ^{r_nos, r_count};

  // Faults are detected before any strobe is raised, so a faulting instruction leaves no trace
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    err     = F_NONE;
    s_push  = 1'b0;
    s_pop   = 1'b0;
    s_rep   = 1'b0;
    s_din   = '0;
    r_push  = 1'b0;
    r_pop   = 1'b0;
    imem_re = 1'b0;
    dmem_re = 1'b0;
    dmem_we = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_re = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_PUSHI: if (s_full) err = F_OVERFLOW;
                    else begin s_push = 1'b1; s_din = imm; end
          OP_LOAD:  if (s_full) err = F_OVERFLOW;
                    else begin dmem_re = 1'b1; state_d = S_MEM; end
          OP_STORE: if (s_empty) err = F_UNDERFLOW;
                    else begin dmem_we = 1'b1; s_pop = 1'b1; end
          OP_DUP:   if (s_empty) err = F_UNDERFLOW;
                    else if (s_full) err = F_OVERFLOW;
                    else begin s_push = 1'b1; s_din = s_tos; end
          OP_DROP:  if (s_empty) err = F_UNDERFLOW;
                    else s_pop = 1'b1;
          OP_JMP:   pc_d = target;
          OP_JZ:    if (s_empty) err = F_UNDERFLOW;
                    else begin
                      s_pop = 1'b1;
                      if (s_tos == '0) pc_d = target;
                    end
          OP_CALL:  if (r_full) err = F_OVERFLOW;
                    else begin r_push = 1'b1; pc_d = target; end
          OP_RET:   if (r_empty) err = F_UNDERFLOW;
                    else begin r_pop = 1'b1; pc_d = r_tos; end
          OP_HALT:  state_d = S_HALT;
          OP_NOT:   if (s_empty) err = F_UNDERFLOW;
                    else begin s_rep = 1'b1; s_din = alu_res; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
                    if (s_count < SPW'(2)) err = F_UNDERFLOW;
                    else begin s_pop = 1'b1; s_rep = 1'b1; s_din = alu_res; end
          default:  err = F_ILLEGAL;
        endcase
        if (err != F_NONE) begin
          fault_d = err;
          state_d = S_HALT;
        end
      end
      S_MEM: begin
        s_push  = 1'b1;
        s_din   = dmem_rdata;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = ir_q[DA_WIDTH-1:0];
  assign dmem_wdata = s_tos;
  assign halted     = (state_q == S_HALT);
  assign fault      = fault_q;
  assign sp         = s_count;
  assign tos        = s_tos;

endmodule

// File: tb/tb_stack_cpu_core.sv
// Directed program vectors for stack_cpu_core with synchronous-read memory models.
module tb_stack_cpu_core;

  localparam int DW = 16;
  localparam int PW = 6;
  localparam int AW = 7;
  localparam int SD = 32;
  localparam int RD = 4;

  localparam logic [4:0] NOP = 5'h00, PUSHI = 5'h01, LOAD = 5'h02, STORE = 5'h03;
  localparam logic [4:0] DUP = 5'h04, DROP = 5'h05, JMP = 5'h06, JZ = 5'h07;
  localparam logic [4:0] CALL = 5'h08, RET = 5'h09, HLT = 5'h0F, ILL = 5'h0A;
  localparam logic [4:0] ADD = 5'h10, SUB = 5'h11, AND_ = 5'h12, OR_ = 5'h13;
  localparam logic [4:0] XOR_ = 5'h14, SHL = 5'h15, SHR = 5'h16, NOT_ = 5'h17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [PW-1:0]       imem_addr;
  logic                imem_re;
  logic [15:0]         imem_rdata = '0;
  logic [AW-1:0]       dmem_addr;
  logic                dmem_re;
  logic                dmem_we;
  logic [DW-1:0]       dmem_wdata;
  logic [DW-1:0]       dmem_rdata = '0;
  logic                halted;
  logic [1:0]          fault;
  logic [$clog2(SD):0] sp;
  logic [DW-1:0]       tos;

  logic [15:0]   imem [0:(1<<PW)-1];
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  int wr_cnt  = 0;
  int last_wa = 0;
  int last_wd = 0;

  int n_chk  = 0;
  int n_fail = 0;

  stack_cpu_core #(
    .DWIDTH(DW), .PC_WIDTH(PW), .DA_WIDTH(AW), .SDEPTH(SD), .RDEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .halted(halted), .fault(fault), .sp(sp), .tos(tos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_re) imem_rdata <= imem[imem_addr];
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wdata;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= int'(dmem_addr);
      last_wd <= int'(dmem_wdata);
    end
  end

  typedef struct {
    string name;
    int    start;
    int    len;
    int    f;
    int    sp;
    int    tos;
    int    cyc;
    bit    wr;
    int    wa;
    int    wd;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] pool[$];
  int          mark = 0;

  function automatic logic [15:0] ins(input logic [4:0] op, input int arg);
    return {op, arg[10:0]};
  endfunction

  task automatic p(input logic [4:0] op, input int arg);
    pool.push_back(ins(op, arg));
  endtask

  task automatic v(input string nm, input int f, input int s, input int t, input int c,
                   input bit wr, input int wa, input int wd);
    vec_t e;
    e.name = nm; e.start = mark; e.len = pool.size() - mark;
    e.f = f; e.sp = s; e.tos = t; e.cyc = c; e.wr = wr; e.wa = wa; e.wd = wd;
    vecs.push_back(e);
    mark = pool.size();
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int start, input int len);
    for (int i = 0; i < (1 << PW); i++) imem[i] = ins(HLT, 0);
    for (int i = 0; i < len; i++) imem[i] = pool[start + i];
  endtask

  task automatic run(input int limit, output int cycles);
    @(negedge clk);
    rst = 1'b1;
    cycles = 0;
    while (!halted && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int w0;
    bit seen;

    #12;
    check("rst.halted", halted, 0);
    check("rst.fault", fault, 0);
    check("rst.sp", sp, 0);
    check("rst.tos", tos, 0);
    check("rst.imem_addr", imem_addr, 0);
    check("rst.dmem_we", dmem_we, 0);
    check("rst.dmem_re", dmem_re, 0);

    p(PUSHI, 5); p(PUSHI, 3); p(ADD, 0); p(STORE, 10); p(HLT, 0);
    v("add_store", 0, 0, 0, 15, 1, 10, 8);
    p(PUSHI, 0); p(JZ, 4); p(PUSHI, 7); p(HLT, 0); p(PUSHI, 9); p(HLT, 0);
    v("jz_taken", 0, 1, 9, 12, 0, 0, 0);
    p(CALL, 3); p(HLT, 0); p(NOP, 0); p(PUSHI, 1); p(RET, 0);
    v("call_ret", 0, 1, 1, 12, 0, 0, 0);
    p(ADD, 0);
    v("add_empty", 2, 0, 0, 3, 0, 0, 0);
    p(ILL, 0);
    v("illegal", 3, 0, 0, 3, 0, 0, 0);
    p(PUSHI, 3); p(PUSHI, 5); p(SUB, 0); p(HLT, 0);
    v("sub_wrap", 0, 1, 16'hFFFE, 12, 0, 0, 0);
    p(PUSHI, 1); p(PUSHI, 15); p(SHL, 0); p(HLT, 0);
    v("shl15", 0, 1, 16'h8000, 12, 0, 0, 0);
    p(PUSHI, 16'h400); p(PUSHI, 3); p(SHR, 0); p(HLT, 0);
    v("shr3", 0, 1, 16'h0080, 12, 0, 0, 0);
    p(PUSHI, 16'h6C); p(PUSHI, 16'h3A); p(AND_, 0); p(PUSHI, 16'hF0); p(XOR_, 0); p(HLT, 0);
    v("and_xor", 0, 1, 16'h00D8, 18, 0, 0, 0);
    p(PUSHI, 16'h6C); p(PUSHI, 16'h3A); p(OR_, 0); p(HLT, 0);
    v("or", 0, 1, 16'h007E, 12, 0, 0, 0);
    p(PUSHI, 16'h00F); p(NOT_, 0); p(HLT, 0);
    v("not", 0, 1, 16'hFFF0, 9, 0, 0, 0);
    p(PUSHI, 16'h123); p(STORE, 20); p(LOAD, 20); p(DUP, 0); p(ADD, 0); p(HLT, 0);
    v("store_load", 0, 1, 16'h246, 19, 1, 20, 16'h123);
    p(PUSHI, 1); p(JZ, 3); p(PUSHI, 4); p(HLT, 0);
    v("jz_not_taken", 0, 1, 4, 12, 0, 0, 0);
    p(JMP, 2); p(PUSHI, 1); p(PUSHI, 2); p(HLT, 0);
    v("jmp", 0, 1, 2, 9, 0, 0, 0);
    p(RET, 0);
    v("ret_empty", 2, 0, 0, 3, 0, 0, 0);
    p(CALL, 1); p(CALL, 2); p(CALL, 3); p(CALL, 4); p(CALL, 5);
    v("rs_overflow", 1, 0, 0, 15, 0, 0, 0);
    p(PUSHI, 7); p(PUSHI, 8); p(DROP, 0); p(HLT, 0);
    v("drop", 0, 1, 7, 12, 0, 0, 0);
    p(DUP, 0);
    v("dup_empty", 2, 0, 0, 3, 0, 0, 0);
    p(PUSHI, 16'h7FF); p(HLT, 0);
    v("pushi_max", 0, 1, 16'h07FF, 6, 0, 0, 0);
    p(PUSHI, 9); p(SUB, 0);
    v("sub_one_operand", 2, 1, 9, 6, 0, 0, 0);
    p(STORE, 3);
    v("store_empty", 2, 0, 0, 3, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = 1'b0;
      load(vecs[i].start, vecs[i].len);
      @(negedge clk);
      w0 = wr_cnt;
      run(200, cyc);
      check($sformatf("%s.halted", vecs[i].name), halted, 1);
      check($sformatf("%s.fault", vecs[i].name), fault, vecs[i].f);
      check($sformatf("%s.sp", vecs[i].name), sp, vecs[i].sp);
      check($sformatf("%s.tos", vecs[i].name), tos, vecs[i].tos);
      check($sformatf("%s.cycles", vecs[i].name), cyc, vecs[i].cyc);
      if (vecs[i].wr) begin
        check($sformatf("%s.writes", vecs[i].name), wr_cnt - w0, 1);
        check($sformatf("%s.waddr", vecs[i].name), last_wa, vecs[i].wa);
        check($sformatf("%s.wdata", vecs[i].name), last_wd, vecs[i].wd);
      end else begin
        check($sformatf("%s.writes", vecs[i].name), wr_cnt - w0, 0);
      end
    end

    // 33 pushes into a 32-entry operand stack
    rst = 1'b0;
    mark = pool.size();
    for (int i = 0; i < 33; i++) p(PUSHI, i + 1);
    load(mark, 33);
    @(negedge clk);
    run(300, cyc);
    check("ovf33.halted", halted, 1);
    check("ovf33.fault", fault, 1);
    check("ovf33.sp", sp, 32);
    check("ovf33.tos", tos, 32);
    check("ovf33.cycles", cyc, 99);

    // reset pulse while STORE is in EXEC
    rst = 1'b0;
    mark = pool.size();
    p(PUSHI, 5); p(STORE, 10); p(HLT, 0);
    load(mark, 3);
    @(negedge clk);
    w0 = wr_cnt;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dmem_we) seen = 1'b1;
    end
    check("rst_mid.store_reached", seen, 1);
    rst = 1'b0;
    #1;
    check("rst_mid.dmem_we", dmem_we, 0);
    check("rst_mid.dmem_re", dmem_re, 0);
    check("rst_mid.halted", halted, 0);
    check("rst_mid.fault", fault, 0);
    check("rst_mid.sp", sp, 0);
    check("rst_mid.tos", tos, 0);
    check("rst_mid.imem_addr", imem_addr, 0);
    @(posedge clk);
    #1;
    check("rst_mid.no_write", wr_cnt - w0, 0);
    run(100, cyc);
    check("rst_mid.rerun_cycles", cyc, 9);
    check("rst_mid.rerun_writes", wr_cnt - w0, 1);
    check("rst_mid.rerun_waddr", last_wa, 10);
    check("rst_mid.rerun_wdata", last_wd, 5);
    check("rst_mid.rerun_sp", sp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
